// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: one-hot state encoding,
// default line settings and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } state_t;

  localparam int DEF_CLK_FREQ = 50000000;
  localparam int DEF_BAUD     = 9600;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, held at zero
// while clr is high so each frame starts on a clean bit boundary.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with registered tx/busy/done outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD      = DEF_BAUD,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic                 tx_n, busy_n, done_n;
  logic                 tick, baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                 par, par_n;
`endif

  assign baud_clr = (state == IDLE);

  baud_tick_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    shift_n = shift;
    idx_n   = idx;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: if (start) begin
        state_n = START;
        shift_n = data;
        idx_n   = '0;
`ifdef UART_TX_PARITY_EN
        par_n   = ^data;
`endif
      end
      START: if (tick) begin
        state_n = DATA;
        idx_n   = '0;
      end
      DATA: if (tick) begin
        shift_n = shift >> 1;
        if (idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
          state_n = PARITY;
`else
          state_n = STOP;
`endif
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      PARITY: if (tick) state_n = STOP;
      STOP: if (tick) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the next state so they land in flops.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      default: tx_n = 1'b1;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx   <= '0;
      tx    <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shift <= shift_n;
      idx   <= idx_n;
      tx    <= tx_n;
      busy  <= busy_n;
      done  <= done_n;
`ifdef UART_TX_PARITY_EN
      par   <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer at 10 clocks per bit.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif
  localparam int FLEN = FRAME * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, busy, done;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, next_free = 0, exp_done = 0, n_done = 0;
  logic [7:0]  sb_q[$];
  bit          mon_act = 1'b0;
  int          mon_t = 0, mon_bad = 0;
  logic [15:0] exp_vec;

  uart_tx_serializer #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Line image of a frame, bit k = level during the k-th bit period.
  function automatic logic [15:0] frame_of(input logic [7:0] d);
    logic [15:0] v;
    v = '1;
    v[0] = 1'b0;
    v[8:1] = d;
`ifdef UART_TX_PARITY_EN
    v[9] = ^d;
`endif
    return v;
  endfunction

  // A start sampled at edge E is taken only once the previous frame's
  // FLEN busy cycles are over; the done cycle itself is already idle.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    data  = d;
    if (cyc + 1 >= next_free) begin
      sb_q.push_back(d);
      next_free = cyc + 1 + FLEN + 1;
      exp_done++;
    end
    @(negedge clk);
    start = 1'b0;
    data  = 8'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 3 * FLEN && !seen; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    if (!seen) chk("done_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      if (cyc >= next_free + 1 && !mon_act) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 1, 0);
  endtask

  always @(negedge clk) if (!rst && done) n_done++;

  // Monitor: a falling tx opens a frame; every cycle of it is compared.
  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act && tx == 1'b0) begin
      mon_act = 1'b1;
      mon_t   = 0;
      mon_bad = 0;
      if (sb_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        exp_vec = '1;
      end else begin
        exp_vec = frame_of(sb_q.pop_front());
      end
    end
    if (mon_act) begin
      if (mon_t < FLEN) begin
        if (tx !== exp_vec[mon_t / CPB] || busy !== 1'b1) mon_bad++;
      end else begin
        chk("frame_bits_busy", mon_bad, 0);
        chk("frame_end_done", {done, busy, tx}, 3'b101);
        mon_act = 1'b0;
      end
      mon_t++;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {tx, busy, done}, 3'b100);
    rst = 1'b0;
    next_free = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", {tx, busy, done}, 3'b100);
    end

    send(8'hA5);
    wait_idle();

    send(8'h3C);
    repeat (38) @(negedge clk);
    send(8'hFF);
    wait_idle();

    send(8'h55);
    wait_done();
    send(8'h0F);
    chk("b2b_start_bit", {tx, busy}, 2'b01);
    wait_idle();

    send(8'h81);
    repeat (34) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_outputs", {tx, busy, done}, 3'b100);
    exp_done--;
    next_free = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h6B);
    wait_idle();

`ifdef UART_TX_PARITY_EN
    send(8'h07);
    wait_idle();
    send(8'h03);
    wait_idle();
`endif

    for (int i = 0; i < 10; i++) begin
      send(8'($urandom));
      repeat ($urandom_range(0, 130)) @(negedge clk);
    end
    wait_idle();

    chk("done_count", n_done, exp_done);
    chk("queue_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
